// File: rtl/coin_pkg.sv
// Shared types and widths for the coin pulse conditioner.
package coin_pkg;

  localparam int unsigned DebounceWidth = 8;
  localparam int unsigned GapWidth      = 8;
  localparam int unsigned TallyWidth    = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEmitD = 2'd1,
    StEmitN = 2'd2,
    StGap   = 2'd3
  } arb_state_e;

  // Dime wins over nickel; nothing pending means stay idle.
  function automatic arb_state_e arbitrate(input logic pend_dime, input logic pend_nickel);
    if (pend_dime) begin
      return StEmitD;
    end else if (pend_nickel) begin
      return StEmitN;
    end
    return StIdle;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [TallyWidth-1:0] sat_inc(input logic [TallyWidth-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: two-flop synchronizer, debounce counter and rising-edge detect.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic                     sync1_q, sync2_q;
  logic                     level_q, level_d, level_prev_q;
  logic [DebounceWidth-1:0] cnt_q, cnt_d, cnt_inc;

  // Synchronize the asynchronous sensor level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the debounced level; adopt the sample once
  // enough have been seen, and restart whenever the sample agrees again.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_inc == DebounceWidth'(DEBOUNCE_CYCLES)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Debounce state and delayed level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign rise = level_q & ~level_prev_q;

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin pulse conditioner: debounces dime/nickel sensors and emits spaced one-cycle pulses.
// Optional feature: define COIN_TALLY_EN to add saturating DimeCount/NickelCount outputs.
module coin_pulse_conditioner
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic DimeRaw,
  input  logic NickelRaw,
  output logic D,
  output logic N,
  output logic Busy,
  output logic Overrun
`ifdef COIN_TALLY_EN
  ,
  output logic [TallyWidth-1:0] DimeCount,
  output logic [TallyWidth-1:0] NickelCount
`endif
);

  logic                dime_rise, nickel_rise;
  logic                pend_dime_q, pend_dime_d, pend_nickel_q, pend_nickel_d;
  logic                clr_dime, clr_nickel;
  logic                overrun_q, overrun_d;
  arb_state_e          state_q, state_d;
  logic [GapWidth-1:0] gap_cnt_q, gap_cnt_d;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dime (
    .clk  (Clock),
    .rst_n(Resetn),
    .raw  (DimeRaw),
    .rise (dime_rise)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_nickel (
    .clk  (Clock),
    .rst_n(Resetn),
    .raw  (NickelRaw),
    .rise (nickel_rise)
  );

  // Arbiter next state and pulse outputs; the last gap cycle arbitrates directly so a waiting
  // coin follows GAP_CYCLES after the previous pulse.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    clr_dime   = 1'b0;
    clr_nickel = 1'b0;
    D          = 1'b0;
    N          = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = arbitrate(pend_dime_q, pend_nickel_q);
      end
      StEmitD: begin
        D         = 1'b1;
        clr_dime  = 1'b1;
        gap_cnt_d = '0;
        state_d   = StGap;
      end
      StEmitN: begin
        N          = 1'b1;
        clr_nickel = 1'b1;
        gap_cnt_d  = '0;
        state_d    = StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapWidth'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = arbitrate(pend_dime_q, pend_nickel_q);
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending flags: a new edge wins over a same-cycle clear; an edge onto an uncleared flag
  // is dropped and recorded in the sticky overrun flag.
  always_comb begin
    pend_dime_d   = pend_dime_q;
    pend_nickel_d = pend_nickel_q;
    overrun_d     = overrun_q;
    if (dime_rise) begin
      if (pend_dime_q && !clr_dime) overrun_d = 1'b1;
      pend_dime_d = 1'b1;
    end else if (clr_dime) begin
      pend_dime_d = 1'b0;
    end
    if (nickel_rise) begin
      if (pend_nickel_q && !clr_nickel) overrun_d = 1'b1;
      pend_nickel_d = 1'b1;
    end else if (clr_nickel) begin
      pend_nickel_d = 1'b0;
    end
  end

  // Arbiter and pending state registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= StIdle;
      gap_cnt_q     <= '0;
      pend_dime_q   <= 1'b0;
      pend_nickel_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      pend_dime_q   <= pend_dime_d;
      pend_nickel_q <= pend_nickel_d;
      overrun_q     <= overrun_d;
    end
  end

  assign Busy    = (state_q != StIdle) | pend_dime_q | pend_nickel_q;
  assign Overrun = overrun_q;

`ifdef COIN_TALLY_EN
  logic [TallyWidth-1:0] dime_cnt_q, nickel_cnt_q;

  // Saturating tallies of emitted pulses.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dime_cnt_q   <= '0;
      nickel_cnt_q <= '0;
    end else begin
      if (state_q == StEmitD) dime_cnt_q <= sat_inc(dime_cnt_q);
      if (state_q == StEmitN) nickel_cnt_q <= sat_inc(nickel_cnt_q);
    end
  end

  assign DimeCount   = dime_cnt_q;
  assign NickelCount = nickel_cnt_q;
`endif

endmodule

// File: doc/coin_pulse_conditioner.md
COIN_PULSE_CONDITIONER -- requirements
Module: coin_pulse_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before a channel's debounced level changes; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles forced after every emitted pulse; legal range 1..255.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 DimeRaw  input  1  raw, asynchronous, bouncing dime-sensor level; high means coin present.
REQ-006 NickelRaw  input  1  raw, asynchronous, bouncing nickel-sensor level; high means coin present.
REQ-007 D  output  1  one-cycle dime pulse to the downstream coin-accumulator FSM.
REQ-008 N  output  1  one-cycle nickel pulse to the downstream coin-accumulator FSM.
REQ-009 Busy  output  1  high whenever the arbiter is not in IDLE or any pending flag is set.
REQ-010 Overrun  output  1  sticky flag: a coin event was dropped.

Function
REQ-011 Each raw input shall pass through a two-flop synchronizer before any other logic.
REQ-012 Per channel, a debounce counter shall reset on any change of the synchronized sample relative to the debounced level, and the debounced level shall take the sample value when the counter reaches DEBOUNCE_CYCLES.
REQ-013 A 0->1 transition of a debounced level shall set that channel's pending flag; 1->0 transitions shall have no effect.
REQ-014 Arbiter states: IDLE, EMIT_D, EMIT_N, GAP.
REQ-015 IDLE: dime pending -> EMIT_D; else nickel pending -> EMIT_N; else stay.
REQ-016 EMIT_D: D=1 for exactly this cycle, clear dime pending, -> GAP; EMIT_N likewise with N.
REQ-017 GAP: D=N=0 for exactly GAP_CYCLES cycles, then -> IDLE.
REQ-018 D and N shall never be high in the same cycle; dime has priority when both are pending.
REQ-019 A rising debounced edge on a channel whose pending flag is already set and not being cleared that cycle shall be dropped and shall set Overrun.
REQ-020 A pending flag cleared in EMIT and set by a new edge in the same cycle shall end set; Overrun shall not be raised.
REQ-021 Latency: with the arbiter IDLE and nothing pending, D or N shall be high in the cycle beginning DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw input high.
REQ-022 Bounces shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no pulse.

Reset
REQ-023 Resetn low shall immediately force: state IDLE; synchronizers, debounced levels, counters and pending flags 0; D=N=Busy=Overrun=0.
REQ-024 Reset mid-pulse or mid-gap shall abort it; a raw input held high through reset release shall produce one pulse after the REQ-021 latency.
REQ-025 Overrun shall clear only on reset.

Configuration
REQ-026 Macro COIN_TALLY_EN defined: add outputs DimeCount and NickelCount, each 8 bits, counting emitted D and N pulses, saturating at 255, and reset to 0.
REQ-027 COIN_TALLY_EN undefined: these ports and their counters shall not exist; all other behaviour is identical.

Structure
REQ-028 Package coin_pkg shall hold the arbiter state encoding, the debounce and gap counter widths (8), and the tally width (8).
REQ-029 Sub-module coin_debounce shall implement the synchronizer, debounce and rising-edge detection, and shall be instantiated once per channel.

Verification
REQ-030 DEBOUNCE_CYCLES=4, DimeRaw 0->1 held 20 cycles -> single D pulse 7 edges later; N stays 0; Busy high from edge detect through end of gap.
REQ-031 NickelRaw toggles with 2-cycle highs for 30 cycles -> no N pulse, Overrun=0.
REQ-032 DimeRaw and NickelRaw rise in the same cycle -> D in cycle t, N in cycle t+1+GAP_CYCLES (t+3 with defaults), never together.
REQ-033 While dime pending during GAP, second debounced dime edge -> Overrun=1, only one D emitted, Overrun held until Resetn low.
REQ-034 Resetn asserted during EMIT_D -> D drops asynchronously, all outputs 0; DimeRaw held high through release -> exactly one D after 7 edges.
REQ-035 With COIN_TALLY_EN, 260 dime events -> DimeCount=255, NickelCount=0.
